// File: rtl/fetch_stage.sv
// fetch_stage: front end of the in-order pipeline.
//
// Owns the program counter, drives the instruction memory address and produces
// F_pc / F_inst / F_BP_taken for the F/D pipeline register. Wrong-path fetches
// are squashed to NOP because the F/D register has no flush input.
//
// Optional feature macro: FETCH_BTB_EN
//   defined   -> direct-mapped BTB with 2-bit saturating counters predicts the
//                next PC and is trained from the EX resolution port.
//   undefined -> no BTB; F_BP_taken is 0 and EX_br_* inputs are ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_D             decode stall, holds the PC
//   MEM_stall           freezes the whole front end (beats EX_taken)
//   EX_taken/EX_target  redirect from EX (beats stall_D)
//   EX_br_*             branch resolution / BTB training port
//   imem_addr/rdata     combinational instruction memory interface
//   F_pc/F_inst/F_BP_taken  outputs to the F/D register
module fetch_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PC_BITS      = 12,
  parameter int unsigned BTB_IDX_BITS = 4,
  parameter int unsigned RESET_PC     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_D,
  input  logic               MEM_stall,
  input  logic               EX_taken,
  input  logic [PC_BITS-1:0] EX_target,
  input  logic               EX_br_valid,
  input  logic [PC_BITS-1:0] EX_br_pc,
  input  logic               EX_br_taken,
  input  logic [PC_BITS-1:0] EX_br_target,
  output logic [PC_BITS-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [PC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]    F_inst,
  output logic               F_BP_taken
);

  localparam logic [XLEN-1:0] Nop = XLEN'(32'h2000_0000);

  logic [PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0] w_pc_next;
  logic               w_pred;
  logic [PC_BITS-1:0] w_pred_target;

`ifdef FETCH_BTB_EN
  localparam int unsigned TagBits = PC_BITS - BTB_IDX_BITS - 2;
  localparam int unsigned Entries = 1 << BTB_IDX_BITS;

  logic [Entries-1:0] r_valid;
  logic [TagBits-1:0] r_tag    [Entries];
  logic [PC_BITS-1:0] r_target [Entries];
  logic [1:0]         r_ctr    [Entries];

  logic [BTB_IDX_BITS-1:0] w_idx;
  logic [TagBits-1:0]      w_tag;
  logic                    w_hit;

  logic [BTB_IDX_BITS-1:0] w_u_idx;
  logic [TagBits-1:0]      w_u_tag;
  logic                    w_u_hit;
  logic                    w_u_en;

  // Lookup reads the array before any same-cycle update lands.
  assign w_idx         = r_pc[BTB_IDX_BITS+1:2];
  assign w_tag         = r_pc[PC_BITS-1:BTB_IDX_BITS+2];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pred        = w_hit && r_ctr[w_idx][1];
  assign w_pred_target = r_target[w_idx];

  assign w_u_idx = EX_br_pc[BTB_IDX_BITS+1:2];
  assign w_u_tag = EX_br_pc[PC_BITS-1:BTB_IDX_BITS+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_en  = EX_br_valid && !MEM_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_u_en && !w_u_hit && EX_br_taken) begin
      r_valid[w_u_idx] <= 1'b1;
    end
  end

  // Tag/target/counter need no reset: they are only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && w_u_en) begin
      if (w_u_hit) begin
        if (EX_br_taken) begin
          r_ctr[w_u_idx]    <= (r_ctr[w_u_idx] == 2'd3) ? 2'd3 : r_ctr[w_u_idx] + 2'd1;
          r_target[w_u_idx] <= EX_br_target;
        end else begin
          r_ctr[w_u_idx] <= (r_ctr[w_u_idx] == 2'd0) ? 2'd0 : r_ctr[w_u_idx] - 2'd1;
        end
      end else if (EX_br_taken) begin
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= EX_br_target;
        r_ctr[w_u_idx]    <= 2'd2;
      end
    end
  end
`else
  logic w_unused;

  assign w_pred        = 1'b0;
  assign w_pred_target = '0;
  assign w_unused      = ^{EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target};
`endif

  always_comb begin
    w_pc_next = r_pc + PC_BITS'(4);
    if (MEM_stall) begin
      w_pc_next = r_pc;
    end else if (EX_taken) begin
      w_pc_next = EX_target;
    end else if (stall_D) begin
      w_pc_next = r_pc;
    end else if (w_pred) begin
      w_pc_next = w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_BITS'(RESET_PC);
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign imem_addr  = r_pc;
  assign F_pc       = r_pc;
  assign F_inst     = EX_taken ? Nop : imem_rdata;
  assign F_BP_taken = w_pred && !EX_taken;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int PcBits = 12;
  localparam int Words  = 1024;
  localparam logic [31:0] NopWord = 32'h2000_0000;
`ifdef FETCH_BTB_EN
  localparam bit BtbEn = 1'b1;
`else
  localparam bit BtbEn = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              stall_D;
  logic              MEM_stall;
  logic              EX_taken;
  logic [PcBits-1:0] EX_target;
  logic              EX_br_valid;
  logic [PcBits-1:0] EX_br_pc;
  logic              EX_br_taken;
  logic [PcBits-1:0] EX_br_target;
  logic [PcBits-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [PcBits-1:0] F_pc;
  logic [31:0]       F_inst;
  logic              F_BP_taken;

  logic [31:0] mem [Words];

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall_D      (stall_D),
    .MEM_stall    (MEM_stall),
    .EX_taken     (EX_taken),
    .EX_target    (EX_target),
    .EX_br_valid  (EX_br_valid),
    .EX_br_pc     (EX_br_pc),
    .EX_br_taken  (EX_br_taken),
    .EX_br_target (EX_br_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .F_pc         (F_pc),
    .F_inst       (F_inst),
    .F_BP_taken   (F_BP_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[11:2]];

  typedef struct {
    int          pc;
    logic [31:0] inst;
    bit          bp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: PC as an integer, BTB as plain per-entry arrays.
  int m_pc;
  bit m_v   [16];
  int m_tag [16];
  int m_tgt [16];
  int m_ctr [16];

  function automatic bit m_predict(input int pc, output int tgt);
    int idx;
    idx = (pc / 4) % 16;
    tgt = m_tgt[idx];
    return BtbEn && m_v[idx] && (m_tag[idx] == pc / 64) && (m_ctr[idx] >= 2);
  endfunction

  task automatic cycle(input bit push, input bit r, input bit sd, input bit ms,
                       input bit ext, input int extgt, input bit brv, input int brpc,
                       input bit brt, input int brtgt);
    bit   pred;
    int   ptgt;
    int   idx;
    bit   hit;
    exp_t e;
    rst          = r;
    stall_D      = sd;
    MEM_stall    = ms;
    EX_taken     = ext;
    EX_target    = PcBits'(extgt);
    EX_br_valid  = brv;
    EX_br_pc     = PcBits'(brpc);
    EX_br_taken  = brt;
    EX_br_target = PcBits'(brtgt);
    pred = m_predict(m_pc, ptgt);
    if (push) begin
      e.pc   = m_pc;
      e.inst = ext ? NopWord : mem[m_pc / 4];
      e.bp   = pred && !ext;
      sbq.push_back(e);
    end
    if (r) begin
      m_pc = 0;
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    end else begin
      if (BtbEn && brv && !ms) begin
        idx = (brpc / 4) % 16;
        hit = m_v[idx] && (m_tag[idx] == brpc / 64);
        if (hit && brt) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = brtgt;
        end else if (hit) begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end else if (brt) begin
          m_v[idx]   = 1'b1;
          m_tag[idx] = brpc / 64;
          m_tgt[idx] = brtgt;
          m_ctr[idx] = 2;
        end
      end
      if (ms) begin
        m_pc = m_pc;
      end else if (ext) begin
        m_pc = extgt;
      end else if (sd) begin
        m_pc = m_pc;
      end else if (pred) begin
        m_pc = ptgt;
      end else begin
        m_pc = (m_pc + 4) % 4096;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic free_run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input int tgt);
    cycle(1, 0, 0, 0, 1, tgt, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a fetch; compare against the queue.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if (F_pc !== PcBits'(mon_e.pc)) begin
        errors++;
        $display("FAIL F_pc got %h want %h at %0t", F_pc, PcBits'(mon_e.pc), $time);
      end
      checks++;
      if (imem_addr !== PcBits'(mon_e.pc)) begin
        errors++;
        $display("FAIL imem_addr got %h want %h at %0t", imem_addr, PcBits'(mon_e.pc), $time);
      end
      checks++;
      if (F_inst !== mon_e.inst) begin
        errors++;
        $display("FAIL F_inst got %h want %h at %0t", F_inst, mon_e.inst, $time);
      end
      checks++;
      if (F_BP_taken !== mon_e.bp) begin
        errors++;
        $display("FAIL F_BP_taken got %b want %b at %0t", F_BP_taken, mon_e.bp, $time);
      end
    end
  end

  initial begin
    int  ext_r;
    int  br_pc;
    for (int i = 0; i < Words; i++) mem[i] = $urandom;
    m_pc = 0;
    rst = 1'b1; stall_D = 1'b0; MEM_stall = 1'b0; EX_taken = 1'b0; EX_target = '0;
    EX_br_valid = 1'b0; EX_br_pc = '0; EX_br_taken = 1'b0; EX_br_target = '0;

    // Reset for two cycles; pc is defined only after the first edge.
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    free_run(4);                                    // 0x000..0x00c
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);  // hold 0x010
    free_run(2);
    cycle(1, 0, 1, 0, 1, 'h100, 0, 0, 0, 0);        // redirect beats stall_D
    free_run(2);
    cycle(1, 0, 0, 1, 1, 'h200, 0, 0, 0, 0);        // MEM_stall beats redirect
    cycle(1, 0, 0, 1, 1, 'h200, 0, 0, 0, 0);
    redirect('h200);
    free_run(2);

    // Train 0x020 -> 0x080, then fetch it.
    cycle(1, 0, 0, 0, 0, 0, 1, 'h020, 1, 'h080);
    redirect('h020);
    free_run(3);
    cycle(1, 0, 0, 0, 0, 0, 1, 'h020, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 'h020, 0, 0);
    redirect('h020);
    free_run(3);

    // Aliasing: 0x420 shares an index with 0x020.
    cycle(1, 0, 0, 0, 0, 0, 1, 'h020, 1, 'h080);
    cycle(1, 0, 0, 0, 0, 0, 1, 'h420, 1, 'h300);
    redirect('h020);
    free_run(2);
    cycle(1, 0, 0, 1, 0, 0, 1, 'h420, 0, 0);        // frozen update is dropped
    redirect('h420);
    free_run(3);

    // Mid-operation reset discards a same-cycle redirect and update.
    cycle(1, 1, 0, 0, 1, 'h300, 1, 'h040, 1, 'h100);
    free_run(3);

    for (int n = 0; n < 3000; n++) begin
      ext_r = $urandom_range(0, 9);
      br_pc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) * 4
                                          : int'($urandom_range(0, 31)) * 4;
      cycle(1, $urandom_range(0, 299) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, ext_r == 0, int'($urandom_range(0, 63)) * 4,
            $urandom_range(0, 2) == 0, br_pc, $urandom_range(0, 2) != 0,
            int'($urandom_range(0, 63)) * 4);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
